hilo_mul_unit: RTL and testbench

//   Parametrised HI/LO register pair with an integrated iterative shift-add multiplier.

---
 rtl/hilo_mul_if.sv | 23 ++
 rtl/hilo_mul_unit.sv | 64 ++++++
 tb/tb_hilo_mul_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_mul_if.sv
// hilo_mul_if: HI/LO write, multiply request and read/status bundle for hilo_mul_unit
interface hilo_mul_if #(parameter int WIDTH = 32);
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] wb_hi;
  logic [WIDTH-1:0] wb_lo;
  logic             mul_start;
  logic             mul_signed;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             busy;
  logic             done;
  modport master (
    output we_hi, we_lo, wb_hi, wb_lo, mul_start, mul_signed, mul_a, mul_b,
    input  r_hi, r_lo, busy, done
  );
  modport slave (
    input  we_hi, we_lo, wb_hi, wb_lo, mul_start, mul_signed, mul_a, mul_b,
    output r_hi, r_lo, busy, done
  );
endinterface

// File: rtl/hilo_mul_unit.sv
// hilo_mul_unit: HI/LO register pair with a WIDTH-cycle shift-add multiplier writing {HI,LO}
module hilo_mul_unit #(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input logic       clk,
  input logic       rst,
  hilo_mul_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, mcand, acc_add, prod;
  logic [WIDTH-1:0]   mplier, hi, lo, mag_a, mag_b;
  logic               neg, last, done_q;
  // Operands are reduced to magnitudes; 0x80..0 stays as-is and reads as 2^(WIDTH-1) unsigned
  always_comb begin
    mag_a     = (bus.mul_signed && bus.mul_a[WIDTH-1]) ? -bus.mul_a : bus.mul_a;
    mag_b     = (bus.mul_signed && bus.mul_b[WIDTH-1]) ? -bus.mul_b : bus.mul_b;
    last      = (state == MUL) && (cnt == CW'(WIDTH-1));
    acc_add   = acc + (mplier[0] ? mcand : '0);
    prod      = neg ? -acc_add : acc_add;
    state_nxt = (state == IDLE && bus.mul_start) ? MUL : last ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (state == IDLE) begin
        if (bus.we_hi) hi <= bus.wb_hi;
        if (bus.we_lo) lo <= bus.wb_lo;
        if (bus.mul_start) begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, mag_a};
          mplier <= mag_b;
          neg    <= bus.mul_signed & (bus.mul_a[WIDTH-1] ^ bus.mul_b[WIDTH-1]);
          cnt    <= '0;
        end
      end else begin
        acc    <= acc_add;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last) {hi, lo} <= prod;
      end
    end
  end
  assign bus.busy = (state == MUL);
  assign bus.done = done_q;
  assign bus.r_hi = (BYPASS != 0 && bus.we_hi && state == IDLE) ? bus.wb_hi : hi;
  assign bus.r_lo = (BYPASS != 0 && bus.we_lo && state == IDLE) ? bus.wb_lo : lo;
endmodule

// File: tb/tb_hilo_mul_unit.sv
// tb_hilo_mul_unit: randomized and directed checks of hilo_mul_unit against an arithmetic model
module tb_hilo_mul_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  hilo_mul_if #(.WIDTH(32)) b1 ();
  hilo_mul_if #(.WIDTH(32)) b0 ();
  hilo_mul_unit #(.WIDTH(32), .BYPASS(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  hilo_mul_unit #(.WIDTH(32), .BYPASS(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, b, input logic s);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(sa * sb);
  endfunction

  // Drives one multiply and observes it over 40 cycles; dis = cycle index for a disturbance pulse
  task automatic run_mul(input logic [31:0] a, b, input logic s, input logic whi,
                         input logic [31:0] whv, input int dis, output int bcnt,
                         output int dpos, output int dcnt, output logic [31:0] hi_mid,
                         output logic [31:0] r_lo_dis);
    @(negedge clk);
    b1.mul_a = a; b1.mul_b = b; b1.mul_signed = s; b1.mul_start = 1'b1;
    b1.we_hi = whi; b1.wb_hi = whv;
    @(negedge clk);
    b1.mul_start = 1'b0; b1.we_hi = 1'b0;
    bcnt = 0; dcnt = 0; dpos = -1; hi_mid = '0; r_lo_dis = '0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (b1.busy) bcnt++;
      if (b1.done) begin dcnt++; if (dpos < 0) dpos = i; end
      if (i == 5) hi_mid = b1.r_hi;
      if (i == dis) begin
        b1.we_lo = 1'b1; b1.wb_lo = 32'hDEAD; b1.mul_start = 1'b1;
        b1.mul_a = $urandom; b1.mul_b = $urandom; b1.mul_signed = 1'($urandom);
        #1 r_lo_dis = b1.r_lo;
      end else begin
        b1.we_lo = 1'b0; b1.mul_start = 1'b0;
      end
    end
  endtask

  task automatic check_mul(input string name, input logic [31:0] a, b, input logic s);
    int bc, dp, dc;
    logic [31:0] hm, rl;
    logic [63:0] p;
    p = ref_prod(a, b, s);
    run_mul(a, b, s, 1'b0, '0, -1, bc, dp, dc, hm, rl);
    checks++;
    if (bc !== 32 || dc !== 1 || dp !== 32) begin
      errors++;
      $display("FAIL %s timing: busy=%0d done=%0d at %0d, want 32/1/32", name, bc, dc, dp);
    end
    checks++;
    if (hm !== m_hi) begin errors++; $display("FAIL %s hi_mid got %h want %h", name, hm, m_hi); end
    checks++;
    if ({b1.r_hi, b1.r_lo} !== p) begin
      errors++;
      $display("FAIL %s product got %h_%h want %h", name, b1.r_hi, b1.r_lo, p);
    end
    {m_hi, m_lo} = p;
  endtask

  task automatic test_reset();
    int bad;
    checks++;
    if (b1.r_hi !== 0 || b1.r_lo !== 0 || b1.busy !== 0 || b1.done !== 0) begin
      errors++;
      $display("FAIL reset_init got hi=%h lo=%h busy=%b done=%b want 0", b1.r_hi, b1.r_lo, b1.busy, b1.done);
    end
    @(negedge clk);
    b1.we_hi = 1; b1.wb_hi = 32'h55; b1.we_lo = 1; b1.wb_lo = 32'h66;
    @(negedge clk);
    b1.we_hi = 0; b1.we_lo = 0;
    b1.mul_a = 7; b1.mul_b = 9; b1.mul_signed = 0; b1.mul_start = 1;
    @(negedge clk);
    b1.mul_start = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (b1.busy !== 1'b1) begin errors++; $display("FAIL reset_pre busy got %b want 1", b1.busy); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b1.busy !== 0 || b1.done !== 0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL reset_abort busy/done seen %0d times want 0", bad); end
    checks++;
    if (b1.r_hi !== 0 || b1.r_lo !== 0) begin
      errors++;
      $display("FAIL reset_abort hi/lo got %h/%h want 0/0", b1.r_hi, b1.r_lo);
    end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_multu_max();
    check_mul("multu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    checks++;
    if (b1.r_hi !== 32'hFFFFFFFE || b1.r_lo !== 32'h1) begin
      errors++;
      $display("FAIL multu_max_const got %h_%h want fffffffe_00000001", b1.r_hi, b1.r_lo);
    end
  endtask

  task automatic test_mult_signed();
    check_mul("mult_neg3x5", 32'hFFFFFFFD, 32'd5, 1'b1);
    checks++;
    if (b1.r_hi !== 32'hFFFFFFFF || b1.r_lo !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL mult_neg3x5_const got %h_%h want ffffffff_fffffff1", b1.r_hi, b1.r_lo);
    end
    check_mul("mult_minmin", 32'h80000000, 32'h80000000, 1'b1);
    checks++;
    if (b1.r_hi !== 32'h40000000 || b1.r_lo !== 32'h0) begin
      errors++;
      $display("FAIL mult_minmin_const got %h_%h want 40000000_00000000", b1.r_hi, b1.r_lo);
    end
    check_mul("mult_min_x_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1);
  endtask

  task automatic test_bypass();
    logic [31:0] old0;
    old0 = b0.r_hi;
    @(negedge clk);
    b1.we_hi = 1; b1.wb_hi = 32'h12345678;
    b0.we_hi = 1; b0.wb_hi = 32'h12345678;
    #1;
    checks++;
    if (b1.r_hi !== 32'h12345678) begin errors++; $display("FAIL bypass1_same got %h want 12345678", b1.r_hi); end
    checks++;
    if (b0.r_hi !== old0) begin errors++; $display("FAIL bypass0_same got %h want %h", b0.r_hi, old0); end
    @(negedge clk);
    b1.we_hi = 0; b0.we_hi = 0;
    #1;
    checks++;
    if (b1.r_hi !== 32'h12345678 || b0.r_hi !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_after got %h/%h want 12345678", b1.r_hi, b0.r_hi);
    end
    m_hi = 32'h12345678;
  endtask

  task automatic test_mid_mul();
    int bc, dp, dc;
    logic [31:0] hm, rl, a, b;
    logic s;
    logic [63:0] p;
    a = $urandom; b = $urandom; s = 1'($urandom);
    p = ref_prod(a, b, s);
    run_mul(a, b, s, 1'b0, '0, 10, bc, dp, dc, hm, rl);
    checks++;
    if (rl !== m_lo) begin errors++; $display("FAIL mid_mul r_lo got %h want %h", rl, m_lo); end
    checks++;
    if (bc !== 32 || dc !== 1 || dp !== 32) begin
      errors++;
      $display("FAIL mid_mul timing: busy=%0d done=%0d at %0d, want 32/1/32", bc, dc, dp);
    end
    checks++;
    if ({b1.r_hi, b1.r_lo} !== p) begin
      errors++;
      $display("FAIL mid_mul product got %h_%h want %h", b1.r_hi, b1.r_lo, p);
    end
    {m_hi, m_lo} = p;
  endtask

  task automatic test_same_cycle();
    int bc, dp, dc;
    logic [31:0] hm, rl;
    run_mul(32'd2, 32'd3, 1'b0, 1'b1, 32'hAAAA, -1, bc, dp, dc, hm, rl);
    checks++;
    if (hm !== 32'hAAAA) begin errors++; $display("FAIL same_cycle hi_mid got %h want 0000aaaa", hm); end
    checks++;
    if (b1.r_hi !== 0 || b1.r_lo !== 6) begin
      errors++;
      $display("FAIL same_cycle product got %h_%h want 00000000_00000006", b1.r_hi, b1.r_lo);
    end
    m_hi = 0; m_lo = 6;
  endtask

  task automatic test_random();
    logic wh, wl;
    logic [31:0] vh, vl;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      wh = 1'($urandom); wl = 1'($urandom); vh = $urandom; vl = $urandom;
      b1.we_hi = wh; b1.wb_hi = vh; b1.we_lo = wl; b1.wb_lo = vl;
      if (wh) m_hi = vh;
      if (wl) m_lo = vl;
      #1;
      checks++;
      if (b1.r_hi !== m_hi || b1.r_lo !== m_lo) begin
        errors++;
        $display("FAIL rand_write got %h/%h want %h/%h", b1.r_hi, b1.r_lo, m_hi, m_lo);
      end
      @(negedge clk);
      b1.we_hi = 0; b1.we_lo = 0;
      check_mul("rand_mul", $urandom, $urandom, 1'($urandom));
    end
  endtask

  initial begin
    {b1.we_hi, b1.we_lo, b1.mul_start, b1.mul_signed} = '0;
    {b1.wb_hi, b1.wb_lo, b1.mul_a, b1.mul_b} = '0;
    {b0.we_hi, b0.we_lo, b0.mul_start, b0.mul_signed} = '0;
    {b0.wb_hi, b0.wb_lo, b0.mul_a, b0.mul_b} = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_bypass();
    test_mid_mul();
    test_same_cycle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
